// File: rtl/vedic_mult_seq.sv
// Iterative sign-magnitude multiplier: retires DIGIT multiplier bits per CALC cycle
// through a DIGIT x WIDTH partial-product adder into a right-shifting accumulator.
module vedic_mult_seq #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    input  logic               start,
    output logic               busy,
    output logic [2*WIDTH-1:0] result,
    output logic               valid_out
);

    localparam int ITER = WIDTH / DIGIT;
    localparam int CW   = $clog2(ITER + 1);

    // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE);
    // valid_out pulses for one cycle with result, and busy is low in that cycle.
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;

    logic [WIDTH+DIGIT-1:0] pp;
    logic [WIDTH+DIGIT-1:0] sum_hi;
    logic [2*WIDTH-1:0]     acc_next;
    logic                   accept;

    // Partial product of |a| and the lowest DIGIT bits still waiting in b_sh_q.
    always_comb begin
        pp = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (b_sh_q[i]) begin
                pp = pp + ({{DIGIT{1'b0}}, a_mag_q} << i);
            end
        end
        sum_hi = {{DIGIT{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + pp;
    end

    // The running sum sits in the top half and slides right DIGIT bits per step,
    // so after ITER steps it lands at its true weight.
    generate
        if (DIGIT < WIDTH) begin : g_shift
            assign acc_next = {sum_hi, acc_q[WIDTH-1:DIGIT]};
        end else begin : g_whole
            assign acc_next = sum_hi;
        end
    endgenerate

    assign accept = start && (state_q != CALC);

    always_comb begin
        state_d  = state_q;
        a_mag_d  = a_mag_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = CALC;
            end
            CALC: begin
                if (cnt_q == CW'(ITER)) begin
                    state_d  = DONE;
                    result_d = neg_q ? -acc_q : acc_q;
                end else begin
                    acc_d  = acc_next;
                    b_sh_d = b_sh_q >> DIGIT;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = start ? CALC : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            a_mag_d = (is_signed && a[WIDTH-1]) ? -a : a;
            b_sh_d  = (is_signed && b[WIDTH-1]) ? -b : b;
            neg_d   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_mag_q  <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_mag_q  <= a_mag_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

    assign busy      = (state_q == CALC);
    assign valid_out = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Bench for vedic_mult_seq: 32x32/DIGIT=4 instance with directed and mixed vectors,
// plus a 16x16/DIGIT=1 instance; a queue-based scoreboard checks value and latency.
module tb_vedic_mult_seq;

    localparam int LAT  = 9;
    localparam int LAT2 = 17;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // 32-bit instance
    logic        rst, start, is_signed, busy, valid_out;
    logic [31:0] a, b;
    logic [63:0] result;

    vedic_mult_seq #(.WIDTH(32), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .is_signed(is_signed),
        .start(start), .busy(busy), .result(result), .valid_out(valid_out)
    );

    // 16-bit instance
    logic        rst2, start2, is_signed2, busy2, valid2;
    logic [15:0] a2, b2;
    logic [31:0] result2;

    vedic_mult_seq #(.WIDTH(16), .DIGIT(1)) u_dut2 (
        .clk(clk), .rst(rst2), .a(a2), .b(b2), .is_signed(is_signed2),
        .start(start2), .busy(busy2), .result(result2), .valid_out(valid2)
    );

    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] exp2_q[$];
    int          exp2_cyc_q[$];
    bit          done2 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] gold32(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sx, sy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic [31:0] gold16(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic signed [31:0] sx, sy;
        if (s) begin
            sx = {{16{x[15]}}, x};
            sy = {{16{y[15]}}, y};
            return sx * sy;
        end
        return {16'b0, x} * {16'b0, y};
    endfunction

    // Monitor for the 32-bit instance: reset values, result hold, and valid pops.
    logic        rst_seen;
    logic [63:0] last_res = '0;
    always @(posedge clk) rst_seen <= rst;

    initial begin
        logic [63:0] e;
        int          ec;
        forever begin
            @(negedge clk);
            if (cyc == 0) continue;
            if (!rst_seen) begin
                check("reset_busy", {63'b0, busy}, 64'd0);
                check("reset_valid", {63'b0, valid_out}, 64'd0);
                check("reset_result", result, 64'd0);
                last_res = '0;
            end else if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {63'b0, valid_out}, 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("result", result, e);
                    check("latency", 64'(cyc), 64'(ec));
                    last_res = e;
                end
            end else begin
                check("result_hold", result, last_res);
            end
        end
    end

    // Monitor for the 16-bit instance.
    initial begin
        logic [31:0] e;
        int          ec;
        forever begin
            @(negedge clk);
            if (cyc == 0 || rst2 !== 1'b1) continue;
            if (valid2) begin
                if (exp2_q.size() == 0) begin
                    check("unexpected_valid16", {63'b0, valid2}, 64'd0);
                end else begin
                    e  = exp2_q.pop_front();
                    ec = exp2_cyc_q.pop_front();
                    check("result16", {32'b0, result2}, {32'b0, e});
                    check("latency16", 64'(cyc), 64'(ec));
                end
            end
        end
    end

    // Waits for busy=0, presents one request and records the expectation at acceptance.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                         input logic [63:0] ev, input bit push);
        int guard = 0;
        while (busy !== 1'b0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check("busy_timeout", {63'b0, busy}, 64'd0);
        a = av; b = bv; is_signed = sv; start = 1'b1;
        @(posedge clk); #1;
        if (push) begin
            exp_q.push_back(ev);
            exp_cyc_q.push_back(cyc + LAT);
        end
        start = 1'b0;
        a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic issue2(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          input logic [31:0] ev);
        int guard = 0;
        while (busy2 !== 1'b0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check("busy16_timeout", {63'b0, busy2}, 64'd0);
        a2 = av; b2 = bv; is_signed2 = sv; start2 = 1'b1;
        @(posedge clk); #1;
        exp2_q.push_back(ev);
        exp2_cyc_q.push_back(cyc + LAT2);
        start2 = 1'b0;
        a2 = 16'($urandom); b2 = 16'($urandom); is_signed2 = 1'($urandom_range(0, 1));
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    initial begin
        wait (cyc >= 50000);
        check("watchdog", 64'(cyc), 64'd0);
        finish_run();
    end

    // 16-bit stream
    initial begin
        logic [15:0] av, bv;
        logic        sv;
        rst2 = 1'b0; start2 = 1'b0; a2 = '0; b2 = '0; is_signed2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst2 = 1'b1;
        issue2(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        issue2(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        issue2(16'h8000, 16'h8000, 1'b1, 32'h40000000);
        issue2(16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA);
        issue2(16'h0000, 16'h8000, 1'b1, 32'h00000000);
        for (int i = 0; i < 300; i++) begin
            av = 16'($urandom);
            bv = 16'($urandom);
            if ($urandom_range(0, 7) == 0) av = 16'h8000;
            if ($urandom_range(0, 7) == 0) bv = 16'hFFFF;
            sv = 1'($urandom_range(0, 1));
            issue2(av, bv, sv, gold16(av, bv, sv));
        end
        done2 = 1'b1;
    end

    // 32-bit directed sequence followed by mixed vectors
    initial begin
        logic [31:0] av, bv;
        logic        sv;
        int          g;
        rst = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // 3x5: busy for exactly the 9 cycles after acceptance, then valid
        issue(32'd3, 32'd5, 1'b0, 64'd15, 1'b1);
        for (int i = 0; i < LAT; i++) begin
            check("busy_high", {63'b0, busy}, 64'd1);
            @(posedge clk); #1;
        end
        check("busy_fall", {63'b0, busy}, 64'd0);
        check("valid_rise", {63'b0, valid_out}, 64'd1);
        @(posedge clk); #1;
        check("valid_one_cycle", {63'b0, valid_out}, 64'd0);

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 1'b1);
        issue(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1);
        issue(32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA, 1'b1);
        issue(32'h00000000, 32'h80000000, 1'b1, 64'h0000000000000000, 1'b1);
        issue(32'h80000000, 32'h00000003, 1'b0, 64'h0000000180000000, 1'b1);
        issue(32'h12345678, 32'h00000010, 1'b0, 64'h0000000123456780, 1'b1);

        // start while busy is ignored; 9x9 is accepted in the DONE cycle
        issue(32'd7, 32'd6, 1'b0, 64'd42, 1'b1);
        a = 32'd100; b = 32'd100; is_signed = 1'b0; start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        g = 0;
        while (valid_out !== 1'b1 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("valid_for_42", {63'b0, valid_out}, 64'd1);
        issue(32'd9, 32'd9, 1'b0, 64'd81, 1'b1);

        // reset on the 4th CALC edge discards the product
        g = 0;
        while ((exp_q.size() > 0 || busy !== 1'b0) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (2) @(posedge clk);
        #1;
        issue(32'd11, 32'd13, 1'b0, 64'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("midreset_busy", {63'b0, busy}, 64'd0);
        check("midreset_valid", {63'b0, valid_out}, 64'd0);
        check("midreset_result", result, 64'd0);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        for (int i = 0; i < 600; i++) begin
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 9))
                0: av = 32'h80000000;
                1: bv = 32'hFFFFFFFF;
                2: av = 32'h0;
                default: ;
            endcase
            sv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            issue(av, bv, sv, gold32(av, bv, sv), 1'b1);
        end

        g = 0;
        while ((exp_q.size() > 0 || exp2_q.size() > 0 || !done2) && g < 20000) begin
            @(posedge clk);
            g++;
        end
        if (g >= 20000) check("drain_timeout", 64'(exp_q.size() + exp2_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        finish_run();
    end

endmodule
